// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and constants for the load/store unit
// Purpose: FSM state encoding, funct3 access-size codes, byte-enable patterns
//          and the funct3 legality check shared by the top and lsu_align.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Stores only have signed-size encodings; unsigned variants are load-only.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        if (is_store) begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end else begin
            ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                 (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane alignment for loads and stores
// Purpose: byte-enable generation, store lane replication, load lane select
//          with sign/zero extension, and misalignment detection.
// Ports:
//   i_offset     in  2   byte offset within the word (addr[1:0])
//   i_funct3     in  3   access size/sign code
//   i_wdata      in  32  raw store data
//   i_rword      in  32  raw memory read word
//   o_be         out 4   byte enables
//   o_wdata      out 32  lane-replicated store data
//   o_rdata      out 32  aligned and extended load data
//   o_misaligned out 1   halfword on odd byte or word on non-zero offset
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
    end

    always_comb begin
        o_be         = 4'b0000;
        o_wdata      = i_wdata;
        o_rdata      = 32'h0;
        o_misaligned = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = BE_BYTE << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'h0, w_byte};
            end
            F3_H, F3_HU: begin
                o_be         = BE_HALF << i_offset;
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                                  : {16'h0, w_half};
                o_misaligned = i_offset[0];
            end
            F3_W: begin
                o_be         = BE_WORD;
                o_wdata      = i_wdata;
                o_rdata      = i_rword;
                o_misaligned = (i_offset != 2'd0);
            end
            default: begin
                o_be    = 4'b0000;
                o_wdata = i_wdata;
                o_rdata = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core-side load/store unit bridging to a ready-handshake memory bus
// Purpose: accepts a held load/store request from the core, stalls it while a
//          single bus transaction is outstanding, returns aligned load data and
//          pulses fault on misaligned/illegal accesses or bus timeout.
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   i_addr, i_wdata, i_funct3   core byte address, store data, size/sign code
//   i_mem_read, i_mem_write     level requests, held while the instruction is held
//   o_stall, o_rdata, o_fault   core hold, load result, one-cycle fault pulse
//   o_bus_req, o_bus_we         bus request (held until i_bus_ready), write flag
//   o_bus_addr, o_bus_wdata     word address, lane-replicated store data
//   o_bus_be                    byte enables
//   i_bus_ready, i_bus_rdata    bus completion and read word (same cycle)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_next_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [31:0] r_cnt;
    logic [31:0] r_rdata;
    logic        r_timed_out;

    logic        w_access;
    logic        w_we;
    logic        w_reject;
    logic        w_start;
    logic        w_timeout_hit;
    logic        w_stall;
    logic        w_fault;
    logic        w_fault_idle;
    logic [1:0]  w_sel_offset;
    logic [2:0]  w_sel_funct3;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_load_data;
    logic        w_misaligned;

    // Both requests high is treated as a store.
    assign w_access = i_mem_read | i_mem_write;
    assign w_we     = i_mem_write;

    // The aligner checks the live request in IDLE and drives the bus from the
    // registered copy afterwards, so bus outputs stay stable during BUS.
    assign w_sel_offset = (r_state == ST_IDLE) ? i_addr[1:0] : r_addr[1:0];
    assign w_sel_funct3 = (r_state == ST_IDLE) ? i_funct3    : r_funct3;

    lsu_align u_align (
        .i_offset     (w_sel_offset),
        .i_funct3     (w_sel_funct3),
        .i_wdata      (r_wdata),
        .i_rword      (i_bus_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
        .o_rdata      (w_load_data),
        .o_misaligned (w_misaligned)
    );

    assign w_reject = w_access & (w_misaligned | ~funct3_legal(i_funct3, w_we));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_stall       = 1'b0;
        w_fault       = 1'b0;
        w_fault_idle  = 1'b0;
        w_start       = 1'b0;
        w_timeout_hit = 1'b0;
        o_bus_req     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    if (w_reject) begin
                        w_fault      = 1'b1;
                        w_fault_idle = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_start      = 1'b1;
                        w_next_state = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                w_stall   = 1'b1;
                o_bus_req = 1'b1;
                if (i_bus_ready) begin
                    w_next_state = ST_DONE;
                end else if (r_cnt == TIMEOUT - 1) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = ST_DONE;
                end
            end
            ST_DONE: begin
                // Timeout fault is reported here, after bus_req has dropped.
                w_fault      = r_timed_out;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_funct3    <= 3'b000;
            r_we        <= 1'b0;
            r_cnt       <= 32'h0;
            r_rdata     <= 32'h0;
            r_timed_out <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr      <= i_addr;
                r_wdata     <= i_wdata;
                r_funct3    <= i_funct3;
                r_we        <= w_we;
                r_cnt       <= 32'h0;
                r_timed_out <= 1'b0;
            end
            if (w_fault_idle) begin
                r_rdata <= 32'h0;
            end
            if (r_state == ST_BUS) begin
                r_cnt <= r_cnt + 32'd1;
                if (i_bus_ready && !r_we) begin
                    r_rdata <= w_load_data;
                end
                if (w_timeout_hit) begin
                    r_rdata     <= 32'h0;
                    r_timed_out <= 1'b1;
                end
            end
            if (r_state == ST_DONE) begin
                r_timed_out <= 1'b0;
            end
        end
    end

    // Core-facing controls are forced low while reset is held, even if the
    // core keeps its request asserted.
    assign o_stall     = w_stall & ~reset;
    assign o_fault     = w_fault & ~reset;
    assign o_rdata     = w_fault_idle ? 32'h0 : r_rdata;
    assign o_bus_we    = r_we;
    assign o_bus_addr  = {r_addr[31:2], 2'b00};
    assign o_bus_wdata = w_wdata_rep;
    assign o_bus_be    = w_be;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    typedef struct {
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic        we;
        int          stall_cyc;
        int          req_cyc;
        int          fault_cyc;
        logic [31:0] rdata;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        stall;
    logic [31:0] rdata;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    acc_t exp_q[$];

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .i_mem_read  (mem_read),
        .i_mem_write (mem_write),
        .i_funct3    (funct3),
        .o_stall     (stall),
        .o_rdata     (rdata),
        .o_fault     (fault),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_wdata (bus_wdata),
        .o_bus_be    (bus_be),
        .i_bus_ready (bus_ready),
        .i_bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    // Independent reference for load extension: shift the word down by lane.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] s;
        s = w >> (8 * int'(off));
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b010:  return w;
            3'b100:  return {24'h0, s[7:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return 32'h0;
        endcase
    endfunction

    // Drives one held request and records what the bus/core side observed.
    // rdy_delay: number of BUS cycles before bus_ready; negative = never.
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rw, input int rdy_delay, output acc_t o);
        bit seen_stall;
        bit finished;
        int cyc;
        o = '{be: 4'h0, baddr: 32'h0, bwdata: 32'h0, we: 1'b0,
              stall_cyc: 0, req_cyc: 0, fault_cyc: 0, rdata: 32'h0};
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        bus_ready = 1'b0; bus_rdata = rw;
        seen_stall = 0; finished = 0; cyc = 0;
        while (!finished && cyc < 40) begin
            #1;
            if (fault) begin
                o.fault_cyc++;
                o.rdata = rdata;
            end
            if (bus_req) begin
                if (o.req_cyc == 0) begin
                    o.be = bus_be; o.baddr = bus_addr; o.bwdata = bus_wdata; o.we = bus_we;
                end
                if (o.req_cyc == rdy_delay) bus_ready = 1'b1;
                o.req_cyc++;
            end
            if (stall) begin
                o.stall_cyc++;
                seen_stall = 1;
            end else begin
                finished = 1;
                if (seen_stall) o.rdata = rdata;
                mem_read = 1'b0; mem_write = 1'b0;
            end
            cyc++;
            @(negedge clk);
            bus_ready = 1'b0;
        end
        if (!finished) o.stall_cyc = -1;
    endtask

    task automatic test_reset();
        mem_read = 1'b1;
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        mem_read = 1'b0;
        @(negedge clk); reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", bus_req); end
    endtask

    task automatic test_sw();
        acc_t o, e;
        exp_q.push_back('{be: 4'b1111, baddr: 32'h100, bwdata: 32'hDEADBEEF, we: 1'b1,
                          stall_cyc: 2, req_cyc: 1, fault_cyc: 0, rdata: 32'h0});
        run_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 32'h0, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL sw_be: got %b expected %b", o.be, e.be); end
        checks++; if (o.baddr !== e.baddr) begin errors++; $display("FAIL sw_addr: got %h expected %h", o.baddr, e.baddr); end
        checks++; if (o.bwdata !== e.bwdata) begin errors++; $display("FAIL sw_wdata: got %h expected %h", o.bwdata, e.bwdata); end
        checks++; if (o.we !== e.we) begin errors++; $display("FAIL sw_we: got %b expected %b", o.we, e.we); end
        checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL sw_stall_cycles: got %0d expected %0d", o.stall_cyc, e.stall_cyc); end
        checks++; if (o.req_cyc != e.req_cyc) begin errors++; $display("FAIL sw_req_cycles: got %0d expected %0d", o.req_cyc, e.req_cyc); end
        checks++; if (bus_req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL sw_back_idle: got req=%b stall=%b expected 0 0", bus_req, stall); end
    endtask

    task automatic test_lb_lbu();
        acc_t o, e;
        logic [2:0] f3s [2];
        f3s[0] = F3_B; f3s[1] = F3_BU;
        exp_q.push_back('{be: 4'b1000, baddr: 32'h200, bwdata: 32'h0, we: 1'b0,
                          stall_cyc: 3, req_cyc: 2, fault_cyc: 0, rdata: 32'hFFFFFF80});
        exp_q.push_back('{be: 4'b1000, baddr: 32'h200, bwdata: 32'h0, we: 1'b0,
                          stall_cyc: 2, req_cyc: 1, fault_cyc: 0, rdata: 32'h00000080});
        for (int i = 0; i < 2; i++) begin
            run_access(1'b1, 1'b0, f3s[i], 32'h203, 32'h0, 32'h80FF0000, 1 - i, o);
            e = exp_q.pop_front();
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL lb%0d_rdata: got %h expected %h", i, o.rdata, e.rdata); end
            checks++; if (o.be !== e.be) begin errors++; $display("FAIL lb%0d_be: got %b expected %b", i, o.be, e.be); end
            checks++; if (o.baddr !== e.baddr) begin errors++; $display("FAIL lb%0d_addr: got %h expected %h", i, o.baddr, e.baddr); end
            checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL lb%0d_stall_cycles: got %0d expected %0d", i, o.stall_cyc, e.stall_cyc); end
        end
    endtask

    task automatic test_sh();
        acc_t o, e;
        exp_q.push_back('{be: 4'b1100, baddr: 32'h100, bwdata: 32'hABCDABCD, we: 1'b1,
                          stall_cyc: 2, req_cyc: 1, fault_cyc: 0, rdata: 32'h0});
        run_access(1'b0, 1'b1, F3_H, 32'h102, 32'h1234ABCD, 32'h0, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.be !== e.be) begin errors++; $display("FAIL sh_be: got %b expected %b", o.be, e.be); end
        checks++; if (o.bwdata !== e.bwdata) begin errors++; $display("FAIL sh_wdata: got %h expected %h", o.bwdata, e.bwdata); end
        checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL sh_stall_cycles: got %0d expected %0d", o.stall_cyc, e.stall_cyc); end
        checks++; if (o.fault_cyc != e.fault_cyc) begin errors++; $display("FAIL sh_fault: got %0d expected %0d", o.fault_cyc, e.fault_cyc); end
    endtask

    task automatic test_illegal();
        acc_t o, e;
        logic        rds [4];
        logic        wrs [4];
        logic [2:0]  f3s [4];
        logic [31:0] as  [4];
        rds[0] = 1; wrs[0] = 0; f3s[0] = F3_W;   as[0] = 32'h102;
        rds[1] = 1; wrs[1] = 0; f3s[1] = F3_HU;  as[1] = 32'h105;
        rds[2] = 1; wrs[2] = 0; f3s[2] = 3'b011; as[2] = 32'h100;
        rds[3] = 0; wrs[3] = 1; f3s[3] = F3_BU;  as[3] = 32'h100;
        for (int i = 0; i < 4; i++) begin
            // Prime rdata with a non-zero load so the forced zero is visible.
            run_access(1'b1, 1'b0, F3_W, 32'h80, 32'h0, 32'h5A5A0001, 0, o);
            exp_q.push_back('{be: 4'h0, baddr: 32'h0, bwdata: 32'h0, we: 1'b0,
                              stall_cyc: 0, req_cyc: 0, fault_cyc: 1, rdata: 32'h0});
            run_access(rds[i], wrs[i], f3s[i], as[i], 32'h0, 32'h0, 0, o);
            e = exp_q.pop_front();
            checks++; if (o.fault_cyc != e.fault_cyc) begin errors++; $display("FAIL illegal%0d_fault: got %0d expected %0d", i, o.fault_cyc, e.fault_cyc); end
            checks++; if (o.req_cyc != e.req_cyc) begin errors++; $display("FAIL illegal%0d_req: got %0d expected %0d", i, o.req_cyc, e.req_cyc); end
            checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL illegal%0d_stall: got %0d expected %0d", i, o.stall_cyc, e.stall_cyc); end
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL illegal%0d_rdata: got %h expected %h", i, o.rdata, e.rdata); end
        end
    endtask

    task automatic test_rd_wr_both();
        acc_t o, e;
        exp_q.push_back('{be: 4'b1111, baddr: 32'h40, bwdata: 32'h11223344, we: 1'b1,
                          stall_cyc: 2, req_cyc: 1, fault_cyc: 0, rdata: 32'h0});
        run_access(1'b1, 1'b1, F3_W, 32'h40, 32'h11223344, 32'h0, 0, o);
        e = exp_q.pop_front();
        checks++; if (o.we !== e.we) begin errors++; $display("FAIL both_we: got %b expected %b", o.we, e.we); end
        checks++; if (o.fault_cyc != e.fault_cyc) begin errors++; $display("FAIL both_fault: got %0d expected %0d", o.fault_cyc, e.fault_cyc); end
        checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL both_stall: got %0d expected %0d", o.stall_cyc, e.stall_cyc); end
    endtask

    task automatic test_timeout();
        acc_t o, e;
        run_access(1'b1, 1'b0, F3_H, 32'h106, 32'h0, 32'h8001_0000, 2, o);
        checks++; if (o.rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata: got %h expected ffff8001", o.rdata); end
        checks++; if (o.stall_cyc != 4) begin errors++; $display("FAIL lh_stall_cycles: got %0d expected 4", o.stall_cyc); end
        exp_q.push_back('{be: 4'b1111, baddr: 32'h300, bwdata: 32'h0, we: 1'b0,
                          stall_cyc: 5, req_cyc: 4, fault_cyc: 1, rdata: 32'h0});
        run_access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, 32'hCAFEF00D, -1, o);
        e = exp_q.pop_front();
        checks++; if (o.req_cyc != e.req_cyc) begin errors++; $display("FAIL to_req_cycles: got %0d expected %0d", o.req_cyc, e.req_cyc); end
        checks++; if (o.fault_cyc != e.fault_cyc) begin errors++; $display("FAIL to_fault: got %0d expected %0d", o.fault_cyc, e.fault_cyc); end
        checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL to_stall_cycles: got %0d expected %0d", o.stall_cyc, e.stall_cyc); end
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL to_rdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (bus_req !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL to_back_idle: got req=%b fault=%b expected 0 0", bus_req, fault); end
    endtask

    task automatic test_reset_mid_bus();
        acc_t o, e;
        @(negedge clk);
        mem_read = 1'b1; funct3 = F3_W; addr = 32'h400; bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_bus_req: got %b expected 1", bus_req); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_mid_req: got %b expected 0", bus_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
        @(negedge clk);
        mem_read = 1'b0;
        reset = 1'b0;
        exp_q.push_back('{be: 4'b1111, baddr: 32'h400, bwdata: 32'h0, we: 1'b0,
                          stall_cyc: 3, req_cyc: 2, fault_cyc: 0, rdata: 32'h0BADC0DE});
        run_access(1'b1, 1'b0, F3_W, 32'h400, 32'h0, 32'h0BADC0DE, 1, o);
        e = exp_q.pop_front();
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL post_rst_rdata: got %h expected %h", o.rdata, e.rdata); end
        checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL post_rst_stall: got %0d expected %0d", o.stall_cyc, e.stall_cyc); end
    endtask

    task automatic test_back_to_back();
        acc_t o, e;
        logic [2:0]  f3s [5];
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  be;
        int          dly;
        f3s[0] = F3_B; f3s[1] = F3_H; f3s[2] = F3_W; f3s[3] = F3_BU; f3s[4] = F3_HU;
        for (int i = 0; i < 8; i++) begin
            f3  = f3s[$urandom_range(0, 4)];
            off = 2'($urandom_range(0, 3));
            if (f3 == F3_H || f3 == F3_HU) off[0] = 1'b0;
            if (f3 == F3_W) off = 2'b00;
            a = $urandom(); a[1:0] = off;
            w = $urandom();
            dly = $urandom_range(0, 2);
            if (f3 == F3_W) be = 4'b1111;
            else if (f3 == F3_H || f3 == F3_HU) be = 4'b0011 << off;
            else be = 4'b0001 << off;
            exp_q.push_back('{be: be, baddr: {a[31:2], 2'b00}, bwdata: 32'h0, we: 1'b0,
                              stall_cyc: dly + 2, req_cyc: dly + 1, fault_cyc: 0,
                              rdata: model_load(f3, off, w)});
            run_access(1'b1, 1'b0, f3, a, 32'h0, w, dly, o);
            e = exp_q.pop_front();
            checks++; if (o.rdata !== e.rdata) begin errors++; $display("FAIL b2b%0d_rdata f3=%b: got %h expected %h", i, f3, o.rdata, e.rdata); end
            checks++; if (o.be !== e.be) begin errors++; $display("FAIL b2b%0d_be: got %b expected %b", i, o.be, e.be); end
            checks++; if (o.baddr !== e.baddr) begin errors++; $display("FAIL b2b%0d_addr: got %h expected %h", i, o.baddr, e.baddr); end
            checks++; if (o.stall_cyc != e.stall_cyc) begin errors++; $display("FAIL b2b%0d_stall: got %0d expected %0d", i, o.stall_cyc, e.stall_cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_lb_lbu();
        test_sh();
        test_illegal();
        test_rd_wr_both();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max BUS-state cycles waited for bus_ready before fault.
REQ-002 clk  in  1  system clock, rising-edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 addr  in  32  byte address from core ALU result.
REQ-005 wdata  in  32  store data from core rs2 read port.
REQ-006 mem_read  in  1  core load request, level, valid while instruction held.
REQ-007 mem_write  in  1  core store request, level.
REQ-008 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 stall  out  1  core PC/register-write hold; high while access outstanding.
REQ-010 rdata  out  32  load result, aligned and extended, feeds core memOut.
REQ-011 fault  out  1  one-cycle pulse on misaligned, illegal funct3 or timeout.
REQ-012 bus_req  out  1  memory request, held until bus_ready.
REQ-013 bus_we  out  1  1 = write transaction.
REQ-014 bus_addr  out  32  word address, {addr[31:2],2'b00}.
REQ-015 bus_wdata  out  32  store data, lane-replicated.
REQ-016 bus_be  out  4  byte enables.
REQ-017 bus_ready  in  1  memory completion; read data valid same cycle.
REQ-018 bus_rdata  in  32  memory read word.

Function
REQ-019 FSM states IDLE, BUS, DONE; encoding from shared package.
REQ-020 IDLE: access = mem_read|mem_write; legal access -> stall=1 combinationally, register addr/wdata/funct3/we, go BUS.
REQ-021 mem_read and mem_write both high: treat as store, no fault.
REQ-022 Illegal access (H at addr[0]=1; W at addr[1:0]!=0; load funct3 011/110/111; store funct3 other than 000/001/010): no bus transaction, stall=0, fault=1 that cycle, rdata=0, stay IDLE.
REQ-023 BUS: bus_req=1, stall=1; bus_addr/bus_we/bus_be/bus_wdata stable from registered values until bus_ready.
REQ-024 BUS with bus_ready=1: capture extended load data into rdata register, go DONE; stores capture nothing.
REQ-025 BUS cycle counter reaching TIMEOUT without bus_ready: bus_req drops, fault pulses one cycle, rdata=0, go DONE.
REQ-026 DONE: stall=0, rdata valid; unconditional return to IDLE next cycle (no re-trigger on same instruction).
REQ-027 Minimum access latency 3 cycles (IDLE, BUS with immediate ready, DONE); each extra wait cycle adds one.
REQ-028 bus_be: B -> 1<<addr[1:0]; H -> 4'b0011<<addr[1:0]; W -> 4'b1111.
REQ-029 bus_wdata: B -> byte replicated x4; H -> halfword replicated x2; W -> wdata.
REQ-030 Loads: select lane by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W passthrough.
REQ-031 rdata holds last value outside DONE; bus_wdata/bus_addr outside BUS don't-care but deterministic.

Reset
REQ-032 Reset asserted (any cycle, including mid-BUS): state IDLE, bus_req=0, stall=0, fault=0, rdata=0, counter=0, immediately (asynchronous).
REQ-033 After reset deassertion, no access begins until the first clk edge with mem_read|mem_write high.

Structure
REQ-034 Shared package holds state enum, funct3 size constants (B/H/W/BU/HU), bus_be patterns.
REQ-035 One combinational sub-module lsu_align: byte-enable generation, store lane replication, load lane select/extension, misalignment detect.

Verification
REQ-036 SW addr=0x100 wdata=0xDEADBEEF, bus_ready on 1st BUS cycle -> bus_be=1111, bus_addr=0x100, stall high 2 cycles, low in DONE.
REQ-037 LB addr=0x203, bus_rdata=0x80FF_0000 -> rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-038 SH addr=0x102 wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD.
REQ-039 LW addr=0x102 -> fault pulse, no bus_req, stall=0, rdata=0.
REQ-040 LW with bus_ready never asserted, TIMEOUT=4 -> bus_req high 4 cycles, fault pulse, DONE then IDLE, rdata=0.
REQ-041 Reset asserted mid-BUS wait -> bus_req and stall drop same cycle; next LW completes normally.
